// File: rtl/burst_line_memory.sv
// Main-memory model for the core's cache controller: serves whole-line bursts in
// critical-word-first wrap order, or single-word accesses, after a fixed latency.
module burst_line_memory #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 3,
    parameter int INDEX_W = 5,
    parameter int OFF_W   = 2,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic               req_single,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic [INDEX_W-1:0] req_index,
    input  logic [OFF_W-1:0]   req_word,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               rd_valid,
    output logic [DATA_W-1:0]  rd_data,
    output logic [OFF_W-1:0]   beat_word,
    output logic               busy,
    output logic               done
);

    localparam int ADDR_W = TAG_W + INDEX_W + OFF_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LINE   = 1 << OFF_W;
    localparam int CNT_W  = OFF_W + 1;
    localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 write_q, write_d;
    logic                 single_q, single_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [INDEX_W-1:0]   index_q, index_d;
    logic [OFF_W-1:0]     word_q, word_d;
    logic [CNT_W-1:0]     k_q, k_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [OFF_W-1:0]     beat_word_q, beat_word_d;
    logic                 rd_valid_q, rd_valid_d;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [DATA_W-1:0]    mem_rd_q;

    logic                 accept;
    logic                 last_beat;
    logic [ADDR_W-1:0]    rd_addr;
    logic [ADDR_W-1:0]    wr_addr;

    assign accept    = req_valid && (state_q == ST_IDLE);
    assign last_beat = single_q || (k_q == CNT_W'(LINE - 1));

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        single_d = single_q;
        tag_d    = tag_q;
        index_d  = index_q;
        word_d   = word_q;
        k_d      = k_q;
        wait_d   = wait_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    write_d  = req_write;
                    single_d = req_single;
                    tag_d    = req_tag;
                    index_d  = req_index;
                    word_d   = req_word;
                    k_d      = '0;
                    wait_d   = '0;
                    state_d  = (LATENCY > 0) ? ST_WAIT : ST_BURST;
                end
            end
            ST_WAIT: begin
                if (wait_q == WAIT_W'(LATENCY - 1)) begin
                    state_d = ST_BURST;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_BURST: begin
                if (last_beat) begin
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Everything below describes the beat of the *next* cycle, so the array
        // read can be launched one cycle ahead of the registered read port.
        beat_word_d = (state_d == ST_BURST) ? (word_d + k_d[OFF_W-1:0]) : '0;
        rd_valid_d  = (state_d == ST_BURST) && !write_d;
    end

    assign rd_addr = {tag_d, index_d, beat_word_d};
    assign wr_addr = {tag_q, index_q, beat_word_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            single_q    <= 1'b0;
            tag_q       <= '0;
            index_q     <= '0;
            word_q      <= '0;
            k_q         <= '0;
            wait_q      <= '0;
            beat_word_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            single_q    <= single_d;
            tag_q       <= tag_d;
            index_q     <= index_d;
            word_q      <= word_d;
            k_q         <= k_d;
            wait_q      <= wait_d;
            beat_word_q <= beat_word_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Storage is never reset; a write beat is gated by the (async-reset) state,
    // so an aborted burst drops its remaining beats.
    always_ff @(posedge clk) begin
        if ((state_q == ST_BURST) && write_q) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_valid_d) begin
            mem_rd_q <= mem[rd_addr];
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_valid_q ? mem_rd_q : '0;
    assign beat_word = beat_word_q;

endmodule

// File: tb/tb_burst_line_memory.sv
// Scoreboard bench: instance 0 uses LATENCY=2, instance 1 uses LATENCY=0.
module tb_burst_line_memory;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic        req_single [2];
    logic [2:0]  req_tag    [2];
    logic [4:0]  req_index  [2];
    logic [1:0]  req_word   [2];
    logic [31:0] wr_data    [2];
    logic        rd_valid   [2];
    logic [31:0] rd_data    [2];
    logic [1:0]  beat_word  [2];
    logic        busy       [2];
    logic        done       [2];

    logic [31:0] wr_line [2][4];
    logic [31:0] model   [2][1024];

    assign wr_data[0] = wr_line[0][beat_word[0]];
    assign wr_data[1] = wr_line[1][beat_word[1]];

    burst_line_memory #(.LATENCY(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_single(req_single[0]), .req_tag(req_tag[0]),
        .req_index(req_index[0]), .req_word(req_word[0]), .wr_data(wr_data[0]),
        .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .beat_word(beat_word[0]),
        .busy(busy[0]), .done(done[0])
    );

    burst_line_memory #(.LATENCY(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_single(req_single[1]), .req_tag(req_tag[1]),
        .req_index(req_index[1]), .req_word(req_word[1]), .wr_data(wr_data[1]),
        .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .beat_word(beat_word[1]),
        .busy(busy[1]), .done(done[1])
    );

    typedef struct {
        int          dut;
        int          cyc;
        logic [1:0]  w;
        logic [31:0] d;
    } rd_exp_t;

    typedef struct {
        int dut;
        int cyc;
    } done_exp_t;

    rd_exp_t   rd_q[$];
    done_exp_t done_q[$];

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_valid[i]) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", rd_valid[i], 0);
                end else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    chk("rd_dut", i, e.dut);
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_beat_word", beat_word[i], e.w);
                    chk("rd_data", rd_data[i], e.d);
                    $display("dut%0d cyc %0d read beat word %0d data 0x%08h", i, cyc, beat_word[i], rd_data[i]);
                end
            end else if (busy[i]) begin
                chk("rd_data_zero", rd_data[i], 0);
            end
            if (done[i]) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", done[i], 0);
                end else begin
                    done_exp_t e;
                    e = done_q.pop_front();
                    chk("done_dut", i, e.dut);
                    chk("done_cycle", cyc, e.cyc);
                    $display("dut%0d cyc %0d done", i, cyc);
                end
            end
        end
    end

    // Called at a falling edge; drives one request for a cycle and books its expectations.
    task automatic issue(input int d, input logic wr, input logic sg,
                         input logic [2:0] tg, input logic [4:0] ix, input logic [1:0] wd);
        int         t;
        int         b;
        int         lat;
        logic [1:0] w;
        logic [9:0] a;
        t   = cyc;
        b   = sg ? 1 : 4;
        lat = (d == 0) ? 2 : 0;
        chk("req_ready", req_ready[d], 1);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_single[d] = sg;
        req_tag[d]    = tg;
        req_index[d]  = ix;
        req_word[d]   = wd;
        for (int k = 0; k < b; k++) begin
            w = wd + 2'(k);
            a = {tg, ix, w};
            if (wr) model[d][a] = wr_line[d][w];
            else    rd_q.push_back('{d, t + lat + 1 + k, w, model[d][a]});
        end
        done_q.push_back('{d, t + lat + b + 1});
        $display("dut%0d cyc %0d request %s %s tag %0d index %0d word %0d",
                 d, t, wr ? "write" : "read", sg ? "single" : "burst", tg, ix, wd);
        @(negedge clk);
        req_valid[d]  = 1'b0;
        req_write[d]  = 1'($urandom);
        req_single[d] = 1'($urandom);
        req_tag[d]    = 3'($urandom);
        req_index[d]  = 5'($urandom);
        req_word[d]   = 2'($urandom);
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready[d] && done_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", done_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input int d);
        chk("rst_req_ready", req_ready[d], 1);
        chk("rst_busy", busy[d], 0);
        chk("rst_done", done[d], 0);
        chk("rst_rd_valid", rd_valid[d], 0);
        chk("rst_rd_data", rd_data[d], 0);
        chk("rst_beat_word", beat_word[d], 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b1;  req_valid[i] = 1'b0; req_write[i] = 1'b0; req_single[i] = 1'b0;
            req_tag[i] = '0;  req_index[i] = '0;   req_word[i] = '0;
            for (int j = 0; j < 4; j++) wr_line[i][j] = '0;
        end
        #1;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        #1;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Single write then single read of the same word.
        wr_line[0][1] = 32'hDEAD_BEEF;
        issue(0, 1'b1, 1'b1, 3'd5, 5'd3, 2'd1);
        wait_idle(0);
        issue(0, 1'b0, 1'b1, 3'd5, 5'd3, 2'd1);
        wait_idle(0);

        // Burst write from word 0, wrapped burst read from word 2.
        for (int j = 0; j < 4; j++) wr_line[0][j] = 32'hA0 + j;
        issue(0, 1'b1, 1'b0, 3'd1, 5'd7, 2'd0);
        wait_idle(0);
        issue(0, 1'b0, 1'b0, 3'd1, 5'd7, 2'd2);
        wait_idle(0);

        // Requests while busy must be dropped.
        wr_line[0][0] = 32'h5555_0000;
        issue(0, 1'b1, 1'b1, 3'd2, 5'd4, 2'd0);
        wait_idle(0);
        for (int j = 0; j < 4; j++) wr_line[0][j] = 32'hBAD0_BAD0;
        issue(0, 1'b0, 1'b0, 3'd1, 5'd7, 2'd3);
        for (int p = 0; p < 2; p++) begin
            req_valid[0] = 1'b1; req_write[0] = 1'b1; req_single[0] = 1'b1;
            req_tag[0] = 3'd2;   req_index[0] = 5'd4; req_word[0] = 2'd0;
            @(negedge clk);
            req_valid[0] = 1'b0;
            @(negedge clk);
        end
        wait_idle(0);
        issue(0, 1'b0, 1'b1, 3'd2, 5'd4, 2'd0);
        wait_idle(0);

        // A few random full-line round trips.
        for (int r = 0; r < 3; r++) begin
            logic [2:0] tg;
            logic [4:0] ix;
            tg = 3'($urandom);
            ix = 5'($urandom);
            for (int j = 0; j < 4; j++) wr_line[0][j] = $urandom;
            issue(0, 1'b1, 1'b0, tg, ix, 2'($urandom));
            wait_idle(0);
            issue(0, 1'b0, 1'b0, tg, ix, 2'($urandom));
            wait_idle(0);
        end

        // Reset in the middle of a write burst: beats 0-1 land, 2-3 are lost.
        for (int j = 0; j < 4; j++) wr_line[0][j] = 32'h100 + j;
        issue(0, 1'b1, 1'b0, 3'd6, 5'd9, 2'd0);
        wait_idle(0);
        for (int j = 0; j < 4; j++) wr_line[0][j] = 32'h200 + j;
        issue(0, 1'b1, 1'b0, 3'd6, 5'd9, 2'd0);
        void'(done_q.pop_back());
        model[0][{3'd6, 5'd9, 2'd2}] = 32'h102;
        model[0][{3'd6, 5'd9, 2'd3}] = 32'h103;
        repeat (4) @(negedge clk);
        chk("abort_beat_word", beat_word[0], 2);
        rst_n[0] = 1'b0;
        #1;
        chk_reset_outputs(0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        issue(0, 1'b0, 1'b0, 3'd6, 5'd9, 2'd1);
        wait_idle(0);

        // Zero-latency instance: first read beat right after accept.
        for (int j = 0; j < 4; j++) wr_line[1][j] = 32'hC0 + j;
        issue(1, 1'b1, 1'b0, 3'd0, 5'd1, 2'd0);
        wait_idle(1);
        issue(1, 1'b0, 1'b0, 3'd0, 5'd1, 2'd1);
        wait_idle(1);

        repeat (3) @(negedge clk);
        chk("rd_queue_left", rd_q.size(), 0);
        chk("done_queue_left", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/burst_line_memory.md
# burst_line_memory

Parametrised main-memory model serving cache-line bursts to the cache controller of the RISC-V core. A request carries tag, line index and critical word. After a programmable latency, the block streams the whole line in critical-word-first wrap order, either reading or writing one word per cycle. It also supports single-word accesses and signals completion with a one-cycle `done` pulse.

## Interface
- `DATA_W`, 32, word width in bits
- `TAG_W`, 3, tag field width
- `INDEX_W`, 5, line-index field width
- `OFF_W`, 2, word-offset width; line = 2^OFF_W words; depth = 2^(TAG_W+INDEX_W+OFF_W) words
- `LATENCY`, 2, wait cycles between accept and first beat (0 allowed)

- `clk` in 1 — single clock; all state changes on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `req_valid` in 1 — request present
- `req_ready` out 1 — high only in IDLE; accept = `req_valid & req_ready`
- `req_write` in 1 — 1 = write, 0 = read
- `req_single` in 1 — 1 = one-word access, 0 = full-line burst
- `req_tag` in TAG_W, `req_index` in INDEX_W, `req_word` in OFF_W — address; `req_word` = first beat offset
- `wr_data` in DATA_W — write beat data for the offset on `beat_word`
- `rd_valid` out 1 — `rd_data` valid this cycle
- `rd_data` out DATA_W — read beat data
- `beat_word` out OFF_W — offset of current beat
- `busy` out 1 — not IDLE
- `done` out 1 — one-cycle completion pulse

## Operation
- States: IDLE, WAIT, BURST, DONE.
- IDLE: `req_ready`=1. On accept, latch write, single, tag, index and word. Clear the beat counter k. Go to WAIT if LATENCY>0, else to BURST.
- WAIT: count LATENCY cycles, then go to BURST.
- BURST: beat count = 1 if single, else 2^OFF_W.
  - In beat k, `beat_word` = (word + k) mod 2^OFF_W, wrapping.
  - Beat address = {tag, index, `beat_word`}.
- Read beat: `rd_valid`=1 and `rd_data`=mem[beat address] in the same cycle. Registered outputs; the array read is issued one cycle early.
- Write beat: `wr_data` is sampled at the rising edge ending the beat and written to mem[beat address]. The requester drives `wr_data` from `beat_word`.
- After the last beat go to DONE. DONE: `done`=1 for exactly one cycle, then IDLE.
- `req_valid` outside IDLE is ignored, with no queueing.
- Latched request fields are immune to input changes after accept.
- Write then read of the same address: the read returns the new data; the write commits before any later request is accepted.
- `rd_data` = 0 whenever `rd_valid`=0.

## Timing
- Accept edge at cycle T. WAIT occupies T+1..T+LATENCY. BURST occupies T+LATENCY+1..T+LATENCY+B, where B is the beat count. `done` is high in cycle T+LATENCY+B+1. IDLE resumes at T+LATENCY+B+2.
- The minimum request-to-request spacing is LATENCY+B+2 cycles.
- Reset (`rst_n`=0, asynchronous) forces:
  - state IDLE; `req_ready`=1; `busy`=0; `done`=0; `rd_valid`=0; `rd_data`=0; `beat_word`=0.
  - Memory contents are not reset.
- Reset mid-burst: abort immediately with no `done`. Write beats already committed remain; uncommitted beats are lost.
- Reset release: a request may be accepted on the first rising edge with `rst_n`=1.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle. Outputs take reset values asynchronously: `req_ready`=1, all other outputs 0.
- Single write then single read (LATENCY=2):
  - Write tag=5, index=3, word=1, data 0xDEADBEEF → `done` at T+4.
  - Read of the same address → `rd_valid` at T+3 with 0xDEADBEEF.
- Burst write then burst read with wrap:
  - Write line tag=1, index=7 starting word=0, data 0xA0..0xA3.
  - Read the same line with word=2 → beats `beat_word` 2,3,0,1 carrying 0xA2, 0xA3, 0xA0, 0xA1; `done` the cycle after beat 1.
- LATENCY=0 build: burst read → first `rd_valid` in cycle T+1; `done` at T+5.
- Busy rejection: pulse `req_valid` with a different address during WAIT and BURST → ignored; exactly one `done`; memory unchanged at the second address.
- Reset mid write burst: deassert `rst_n` after beat 1.
  - Beats 0–1 persist; beats 2–3 keep old data; no `done`.
  - A new request is accepted on the first edge after release.
